// File: rtl/conv_pkg.sv
// Shared types and default geometry for the convolution window sequencer.
// Imported by the RTL and by the bench so both agree on sizes.
package conv_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_ISSUE,
        S_WAIT_RES,
        S_FINISH
    } conv_state_t;

    localparam int DEF_IMAGE_WIDTH  = 5;
    localparam int DEF_IMAGE_HEIGHT = 5;
    localparam int DEF_FILTER_SIZE  = 3;
    localparam int DEF_TIMEOUT      = 64;

    // Bit width for a counter of n states, never narrower than one bit.
    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/conv_pos_counter.sv
// Row/column position of the current output window, scanned row-major.
// last_o flags the bottom-right window; advancing past it wraps to (0,0).
module conv_pos_counter #(
    parameter int OUT_W = 3,
    parameter int OUT_H = 3,
    parameter int RW    = 2,
    parameter int CW    = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr_i,
    input  logic          adv_i,
    output logic [RW-1:0] row_o,
    output logic [CW-1:0] col_o,
    output logic          last_o
);
    localparam logic [RW-1:0] ROW_MAX = RW'(OUT_H - 1);
    localparam logic [CW-1:0] COL_MAX = CW'(OUT_W - 1);

    logic [RW-1:0] row_q, row_d;
    logic [CW-1:0] col_q, col_d;

    always_comb begin
        row_d = row_q;
        col_d = col_q;
        if (clr_i) begin
            row_d = '0;
            col_d = '0;
        end else if (adv_i) begin
            if (col_q == COL_MAX) begin
                col_d = '0;
                row_d = (row_q == ROW_MAX) ? '0 : row_q + 1'b1;
            end else begin
                col_d = col_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            row_q <= '0;
            col_q <= '0;
        end else begin
            row_q <= row_d;
            col_q <= col_d;
        end
    end

    assign row_o  = row_q;
    assign col_o  = col_q;
    assign last_o = (row_q == ROW_MAX) && (col_q == COL_MAX);

endmodule

// File: rtl/conv_window_sequencer.sv
// Walks every valid convolution window of one frame, hands each coordinate to
// an external MAC and writes the returned result into the result buffer.
module conv_window_sequencer
    import conv_pkg::*;
#(
    parameter int  IMAGE_WIDTH  = DEF_IMAGE_WIDTH,
    parameter int  IMAGE_HEIGHT = DEF_IMAGE_HEIGHT,
    parameter int  FILTER_SIZE  = DEF_FILTER_SIZE,
    parameter int  TIMEOUT      = DEF_TIMEOUT,
    localparam int OUT_W        = IMAGE_WIDTH - FILTER_SIZE + 1,
    localparam int OUT_H        = IMAGE_HEIGHT - FILTER_SIZE + 1,
    localparam int RW           = clog2_min1(OUT_H),
    localparam int CW           = clog2_min1(OUT_W),
    localparam int AW           = clog2_min1(OUT_H * OUT_W)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          abort,
    output logic          load_req,
    input  logic          load_ack,
    output logic          win_valid,
    input  logic          win_ready,
    output logic [RW-1:0] win_row,
    output logic [CW-1:0] win_col,
    input  logic          res_valid,
    input  logic [15:0]   res_data,
    output logic          res_we,
    output logic [AW-1:0] res_addr,
    output logic [15:0]   res_wdata,
    output logic          busy,
    output logic          done,
    output logic          err
);
    localparam int            WW        = clog2_min1(TIMEOUT);
    localparam logic [WW-1:0] WAIT_LAST = WW'(TIMEOUT - 1);
    localparam logic [AW-1:0] OUT_W_A   = AW'(OUT_W);

    conv_state_t   state_q, state_d;
    logic [WW-1:0] wait_q, wait_d;
    logic          err_q, err_d;
    logic          we_q, we_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [15:0]   wdata_q, wdata_d;

    logic          cnt_clr, cnt_adv, cnt_last;
    logic [RW-1:0] row;
    logic [CW-1:0] col;

    conv_pos_counter #(
        .OUT_W (OUT_W),
        .OUT_H (OUT_H),
        .RW    (RW),
        .CW    (CW)
    ) u_pos (
        .clk    (clk),
        .rst    (rst),
        .clr_i  (cnt_clr),
        .adv_i  (cnt_adv),
        .row_o  (row),
        .col_o  (col),
        .last_o (cnt_last)
    );

    always_comb begin
        state_d = state_q;
        wait_d  = wait_q;
        err_d   = err_q;
        we_d    = 1'b0;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        cnt_clr = 1'b0;
        cnt_adv = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_LOAD;
                    cnt_clr = 1'b1;
                    err_d   = 1'b0;
                end
            end
            S_LOAD: begin
                if (abort)         state_d = S_IDLE;
                else if (load_ack) state_d = S_ISSUE;
            end
            S_ISSUE: begin
                if (abort) begin
                    state_d = S_IDLE;
                end else if (win_ready) begin
                    state_d = S_WAIT_RES;
                    wait_d  = '0;
                end
            end
            S_WAIT_RES: begin
                // Abort outranks a result arriving in the same cycle.
                if (abort) begin
                    state_d = S_IDLE;
                end else if (res_valid) begin
                    we_d    = 1'b1;
                    addr_d  = AW'(row) * OUT_W_A + AW'(col);
                    wdata_d = res_data;
                    cnt_adv = 1'b1;
                    state_d = cnt_last ? S_FINISH : S_ISSUE;
                end else if (wait_q == WAIT_LAST) begin
                    err_d   = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end
            S_FINISH: state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            wait_q  <= '0;
            err_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            err_q   <= err_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
        end
    end

    assign load_req  = (state_q == S_LOAD);
    assign win_valid = (state_q == S_ISSUE);
    assign win_row   = row;
    assign win_col   = col;
    assign res_we    = we_q;
    assign res_addr  = addr_q;
    assign res_wdata = wdata_q;
    assign busy      = (state_q != S_IDLE);
    assign done      = (state_q == S_FINISH) && !abort;
    assign err       = err_q;

endmodule

// File: tb/tb_conv_window_sequencer.sv
// Bench for conv_window_sequencer: a MAC responder, a frame-level reference
// model compared every cycle, and directed scenarios with literal expectations.
module tb_conv_window_sequencer;
    import conv_pkg::*;

    localparam int IW   = DEF_IMAGE_WIDTH;
    localparam int IH   = DEF_IMAGE_HEIGHT;
    localparam int FS   = DEF_FILTER_SIZE;
    localparam int TO   = 8;
    localparam int OW   = IW - FS + 1;
    localparam int OH   = IH - FS + 1;
    localparam int NWIN = OW * OH;
    localparam int RW   = clog2_min1(OH);
    localparam int CW   = clog2_min1(OW);
    localparam int AW   = clog2_min1(OH * OW);

    logic clk = 1'b0, rst = 1'b0, start = 1'b0, abort = 1'b0;
    logic load_ack = 1'b0, win_ready = 1'b0, mac_valid = 1'b0, spur_valid = 1'b0;
    logic res_valid;
    logic [15:0] res_data = '0;
    logic load_req, win_valid, res_we, busy, done, err;
    logic [RW-1:0] win_row;
    logic [CW-1:0] win_col;
    logic [AW-1:0] res_addr;
    logic [15:0]   res_wdata;

    assign res_valid = mac_valid | spur_valid;

    conv_window_sequencer #(
        .IMAGE_WIDTH  (IW),
        .IMAGE_HEIGHT (IH),
        .FILTER_SIZE  (FS),
        .TIMEOUT      (TO)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .abort     (abort),
        .load_req  (load_req),
        .load_ack  (load_ack),
        .win_valid (win_valid),
        .win_ready (win_ready),
        .win_row   (win_row),
        .win_col   (win_col),
        .res_valid (res_valid),
        .res_data  (res_data),
        .res_we    (res_we),
        .res_addr  (res_addr),
        .res_wdata (res_wdata),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
        end
    endtask

    // Image pixel (r,c) = r*IW+c+1, all-ones filter: result is the window sum.
    function automatic int conv_sum(input int r, input int c);
        int s = 0;
        for (int fr = 0; fr < FS; fr++)
            for (int fc = 0; fc < FS; fc++)
                s += (r + fr) * IW + (c + fc) + 1;
        return s;
    endfunction

    // Reference model: phase 0 idle, 1 load, 2 offering window, 3 awaiting
    // result, 4 finishing. Window k maps to (k/OW, k%OW).
    int m_phase = 0, m_k = 0, m_wait = 0, m_addr = 0, m_wdata = 0;
    bit m_err = 0, m_we = 0;

    initial forever begin
        @(posedge clk or posedge rst);
        if (rst) begin
            m_phase = 0; m_k = 0; m_wait = 0; m_err = 0;
            m_we = 0; m_addr = 0; m_wdata = 0;
        end else begin
            m_we = 0;
            case (m_phase)
                0: if (start) begin m_phase = 1; m_k = 0; m_err = 0; end
                1: if (abort) m_phase = 0; else if (load_ack) m_phase = 2;
                2: if (abort) m_phase = 0;
                   else if (win_ready) begin m_phase = 3; m_wait = 0; end
                3: if (abort) m_phase = 0;
                   else if (res_valid) begin
                       m_we = 1; m_addr = m_k; m_wdata = conv_sum(m_k / OW, m_k % OW);
                       if (m_k == NWIN - 1) begin m_k = 0; m_phase = 4; end
                       else begin m_k++; m_phase = 2; end
                   end else begin
                       m_wait++;
                       if (m_wait == TO) begin m_err = 1; m_phase = 0; end
                   end
                default: m_phase = 0;
            endcase
        end
    end

    bit cmp_en = 0;
    initial forever begin
        @(negedge clk);
        if (cmp_en) begin
            check("busy", int'(busy), int'(m_phase != 0));
            check("load_req", int'(load_req), int'(m_phase == 1));
            check("win_valid", int'(win_valid), int'(m_phase == 2));
            check("done", int'(done), int'(m_phase == 4 && !abort));
            check("err", int'(err), int'(m_err));
            check("res_we", int'(res_we), int'(m_we));
            if (m_phase == 2 || rst) begin
                check("win_row", int'(win_row), m_k / OW);
                check("win_col", int'(win_col), m_k % OW);
            end
            if (m_we || rst) begin
                check("res_addr", int'(res_addr), m_addr);
                check("res_wdata", int'(res_wdata), m_wdata);
            end
        end
    end

    // Observation log used by the directed scenarios.
    int wr_addr[$];
    int wr_data[$];
    int done_cnt = 0, stall_seen = 0, wait_cycles = 0;
    initial forever begin
        @(negedge clk);
        if (res_we && !rst) begin
            wr_addr.push_back(int'(res_addr));
            wr_data.push_back(int'(res_wdata));
        end
        if (done) done_cnt++;
        if (win_valid && !win_ready && win_row == RW'(1) && win_col == CW'(2)) stall_seen++;
        if (busy && !win_valid && !load_req && !done) wait_cycles++;
    end

    // MAC / loader responder.
    int stall_k = -1, stall_left = 0, silent_k = -1;
    bit rand_mode = 0;
    initial begin
        bit outstanding = 0, hs, got, clr;
        int lat = 0, out_r = 0, out_c = 0, s_r, s_c, idx;
        forever begin
            @(negedge clk);
            hs  = win_valid && win_ready && !abort && !rst;
            got = mac_valid && !abort && !rst;
            clr = rst || abort || !busy;
            s_r = int'(win_row);
            s_c = int'(win_col);
            @(posedge clk); #1;
            if (clr || got) outstanding = 0;
            if (hs) begin
                outstanding = 1; out_r = s_r; out_c = s_c;
                lat = rand_mode ? $urandom_range(0, 3) : 0;
            end
            mac_valid = 1'b0;
            res_data  = 16'($urandom);
            if (outstanding && (out_r * OW + out_c != silent_k)) begin
                if (lat == 0) begin
                    mac_valid = 1'b1;
                    res_data  = 16'(conv_sum(out_r, out_c));
                end else begin
                    lat--;
                end
            end
            if (win_valid) begin
                idx = int'(win_row) * OW + int'(win_col);
                if (idx == stall_k && stall_left > 0) begin
                    win_ready = 1'b0;
                    stall_left--;
                end else begin
                    win_ready = rand_mode ? ($urandom_range(0, 2) != 0) : 1'b1;
                end
            end else begin
                win_ready = rand_mode ? 1'($urandom_range(0, 1)) : 1'b0;
            end
            load_ack = load_req ? (rand_mode ? 1'($urandom_range(0, 1)) : 1'b1) : 1'b0;
        end
    end

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic clear_log();
        wr_addr.delete(); wr_data.delete();
        done_cnt = 0; stall_seen = 0; wait_cycles = 0;
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while (busy && n < 2000) begin step(); n++; end
        check({name, " frame ends"}, int'(busy), 0);
    endtask

    task automatic run_frame(input string name);
        start = 1'b1; step(); start = 1'b0;
        wait_idle(name);
    endtask

    task automatic check_full_frame(input string name);
        int exp_data[9] = '{63, 72, 81, 108, 117, 126, 153, 162, 171};
        check({name, " writes"}, wr_addr.size(), NWIN);
        for (int i = 0; i < NWIN; i++) begin
            if (i < wr_addr.size()) begin
                check({name, " addr"}, wr_addr[i], i);
                check({name, " data"}, wr_data[i], exp_data[i]);
            end
        end
        check({name, " done pulses"}, done_cnt, 1);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        #1 rst = 1'b1;
        step(); cmp_en = 1;
        repeat (2) step();
        check("reset busy", int'(busy), 0);
        check("reset err", int'(err), 0);
        check("reset res_we", int'(res_we), 0);
        rst = 1'b0;
        repeat (3) step();
        check("no start stays idle", int'(busy), 0);
        check("model conv(0,0)", conv_sum(0, 0), 63);
        check("model conv(2,2)", conv_sum(2, 2), 171);

        clear_log(); run_frame("basic");
        check_full_frame("basic");

        clear_log(); stall_k = 5; stall_left = 3;
        run_frame("stall");
        check("stall cycles at (1,2)", stall_seen, 3);
        check_full_frame("stall");
        stall_k = -1;

        clear_log(); start = 1'b1; step(); start = 1'b0;
        n = 0;
        while (!(res_we && res_addr == AW'(4)) && n < 200) begin step(); n++; end
        check("abort reached addr 4", int'(n < 200), 1);
        step(); abort = 1'b1; step(); abort = 1'b0;
        check("abort busy", int'(busy), 0);
        repeat (3) step();
        check("abort writes", wr_addr.size(), 5);
        check("abort done", done_cnt, 0);
        clear_log(); run_frame("after abort");
        check_full_frame("after abort");

        clear_log(); silent_k = 1;
        run_frame("timeout");
        check("timeout err", int'(err), 1);
        check("timeout done", done_cnt, 0);
        check("timeout writes", wr_addr.size(), 1);
        check("timeout wait cycles", wait_cycles, 1 + TO);
        silent_k = -1;
        clear_log(); start = 1'b1; step(); start = 1'b0;
        check("err cleared by start", int'(err), 0);
        wait_idle("post timeout");
        check_full_frame("post timeout");

        clear_log(); start = 1'b1; step(); start = 1'b0;
        repeat (10) step();
        start = 1'b1; step(); start = 1'b0;
        wait_idle("restart ignored");
        spur_valid = 1'b1; step(); spur_valid = 1'b0;
        repeat (3) step();
        check_full_frame("restart ignored");
        check("idle after spurious", int'(busy), 0);

        clear_log(); silent_k = 3; start = 1'b1; step(); start = 1'b0;
        n = 0;
        while (!(wr_addr.size() == 3 && busy && !win_valid && !load_req) && n < 200) begin
            step(); n++;
        end
        check("reached wait at window 3", int'(n < 200), 1);
        #2 rst = 1'b1; #1;
        check("rst busy", int'(busy), 0);
        check("rst win_row", int'(win_row), 0);
        check("rst res_we", int'(res_we), 0);
        check("rst err", int'(err), 0);
        repeat (2) step();
        rst = 1'b0; silent_k = -1;
        step();
        check("idle after rst", int'(busy), 0);
        clear_log(); run_frame("after rst");
        check_full_frame("after rst");

        rand_mode = 1;
        for (int f = 0; f < 25; f++) begin
            clear_log(); start = 1'b1; step(); start = 1'b0;
            n = 0;
            while (busy && n < 600) begin
                abort = ($urandom_range(0, 149) == 0);
                start = ($urandom_range(0, 19) == 0);
                step(); n++;
            end
            abort = 1'b0; start = 1'b0;
            check("rand frame ends", int'(busy), 0);
            check("rand done at most once", int'(done_cnt <= 1), 1);
            if (done_cnt == 1) check("rand completed writes", wr_addr.size(), NWIN);
            repeat (2) step();
        end
        rand_mode = 0;
        repeat (2) step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
